// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control sequencer: Moore FSM issuing per-step datapath
// controls, a request/ready handshake to a shared variable-latency memory,
// a per-access wait timeout, a sticky illegal-instruction fault state and a
// retired-instruction counter.
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_sel,
  output logic [3:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             fault,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_FAULT     = 4'd15
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU function encodings
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Wait counter only needs to reach MEM_TIMEOUT-1
  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt, wait_d;
  logic [CNT_W-1:0]   retired_q;
  logic               retire;
  logic               mem_stall;

  // State, wait counter and retired counter registers
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= S_FETCH;
      wait_cnt  <= '0;
      retired_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_d;
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // Next-state, per-state datapath controls, wait/timeout and retire strobes
  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    retire     = 1'b0;
    mem_stall  = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_sel    = 1'b0;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    fault      = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          mem_stall = 1'b1;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:              state_d = S_R_EXEC;
          OP_LW, OP_SW:          state_d = S_MEM_ADDR;
          OP_ADDI, OP_ANDI,
          OP_ORI:                state_d = S_I_EXEC;
          OP_BEQ:                state_d = S_BRANCH;
          OP_J:                  state_d = S_JUMP;
          default:               state_d = S_FAULT;
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end

      S_MEM_READ: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else begin
          mem_stall = 1'b1;
        end
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          mem_stall = 1'b1;
        end
      end

      S_R_EXEC: begin
        alu_src_a = 1'b1;
        state_d   = S_R_WB;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: state_d = S_FAULT;
        endcase
      end

      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_I_WB;
        case (opcode)
          OP_ANDI: begin
            alu_op  = ALU_AND;
            ext_sel = 1'b1;
          end
          OP_ORI: begin
            alu_op  = ALU_OR;
            ext_sel = 1'b1;
          end
          default: alu_op = ALU_ADD;
        endcase
      end

      S_I_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = 2'b01;
        pc_write  = alu_zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_FAULT: begin
        fault   = 1'b1;
        alu_op  = '0;
        state_d = S_FAULT;
      end

      default: begin
        alu_op  = '0;
        state_d = S_FAULT;
      end
    endcase

    // Stalled memory step: count, or give up once the budget is spent.
    // Leaving or entering a memory step always restarts the count at zero.
    if (mem_stall) begin
      if ((MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
        state_d = S_FAULT;
      end else begin
        wait_d = wait_cnt + WAIT_W'(1);
      end
    end

    // Controls are forced low for the whole time clear is held, so nothing
    // partial reaches the datapath even though clear lands mid-cycle
    if (clear) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_source  = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      ext_sel    = 1'b0;
      alu_op     = '0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      fault      = 1'b0;
    end
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: an instruction-level
// step-list model checked every cycle, plus directed literal expectations.
module tb_multicycle_control_unit;

  localparam int unsigned TMO = 16;
  localparam int unsigned CW  = 4;

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic [5:0]    opcode = '0;
  logic [5:0]    funct = '0;
  logic          alu_zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0]    pc_source;
  logic          alu_src_a;
  logic [1:0]    alu_src_b;
  logic          ext_sel;
  logic [3:0]    alu_op;
  logic          reg_write, reg_dst, mem_to_reg, fault;
  logic [CW-1:0] retired;
  logic [3:0]    state;

  multicycle_control_unit #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clock(clock), .clear(clear), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_sel(ext_sel), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .fault(fault), .retired(retired), .state(state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Instruction-level view: each opcode maps to a list of step codes that
  // follow DECODE; memory steps (0, 3, 5) hold while not ready.
  int m_st = 0;
  int m_q[$];
  int m_stalls = 0;
  int m_ret = 0;

  function automatic void plan(input logic [5:0] op, input logic [5:0] fn);
    m_q.delete();
    case (op)
      6'b000000: begin
        m_q.push_back(6);
        if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})
          m_q.push_back(7);
        else
          m_q.push_back(15);
      end
      6'b100011: begin m_q.push_back(2); m_q.push_back(3); m_q.push_back(4); end
      6'b101011: begin m_q.push_back(2); m_q.push_back(5); end
      6'b001000, 6'b001100, 6'b001101: begin m_q.push_back(8); m_q.push_back(9); end
      6'b000100: m_q.push_back(10);
      6'b000010: m_q.push_back(11);
      default:   m_q.push_back(15);
    endcase
  endfunction

  // Order: mem_req mem_write i_or_d ir_write pc_write pc_source alu_src_a
  //        alu_src_b ext_sel alu_op reg_write reg_dst mem_to_reg
  function automatic logic [17:0] exp_ctrl(input int st, input logic rdy, input logic z,
                                           input logic [5:0] op, input logic [5:0] fn);
    logic mr, mw, iod, irw, pcw, asa, ext, rw, rd, m2r;
    logic [1:0] pcs, asb;
    logic [3:0] aop;
    {mr, mw, iod, irw, pcw, asa, ext, rw, rd, m2r} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 4'b0010;
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mr = 1; mw = 1; iod = 1; end
      6:  begin
            asa = 1;
            case (fn)
              6'b100010: aop = 4'b0110;
              6'b100100: aop = 4'b0000;
              6'b100101: aop = 4'b0001;
              6'b101010: aop = 4'b0111;
              default:   aop = 4'b0010;
            endcase
          end
      7:  begin rw = 1; rd = 1; end
      8:  begin
            asa = 1; asb = 2'b10;
            if (op == 6'b001100) begin aop = 4'b0000; ext = 1; end
            else if (op == 6'b001101) begin aop = 4'b0001; ext = 1; end
          end
      9:  rw = 1;
      10: begin asa = 1; aop = 4'b0110; pcs = 2'b01; pcw = z; end
      11: begin pcw = 1; pcs = 2'b10; end
      default: aop = 4'b0000;
    endcase
    return {mr, mw, iod, irw, pcw, pcs, asa, asb, ext, aop, rw, rd, m2r};
  endfunction

  wire [17:0] dut_ctrl = {mem_req, mem_write, i_or_d, ir_write, pc_write, pc_source,
                          alu_src_a, alu_src_b, ext_sel, alu_op, reg_write, reg_dst,
                          mem_to_reg};

  // Per-cycle compare against the model, then advance the model
  always @(negedge clock) begin
    if (clear) begin
      chk("reset_ctrl", 32'(dut_ctrl), 32'd0);
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_retired", 32'(retired), 32'd0);
      chk("reset_fault", 32'(fault), 32'd0);
      m_st = 0; m_q.delete(); m_stalls = 0; m_ret = 0;
    end else begin
      chk("ctrl", 32'(dut_ctrl), 32'(exp_ctrl(m_st, mem_ready, alu_zero, opcode, funct)));
      chk("state", 32'(state), 32'(m_st));
      chk("retired", 32'(retired), 32'(m_ret % (1 << CW)));
      chk("fault", 32'(fault), 32'(m_st == 15));
      if (m_st == 15) begin
        // terminal
      end else if ((m_st inside {0, 3, 5}) && !mem_ready) begin
        m_stalls++;
        if (TMO != 0 && m_stalls >= TMO) begin
          m_st = 15;
          m_stalls = 0;
        end
      end else begin
        m_stalls = 0;
        if (m_st == 0) begin
          m_st = 1;
        end else begin
          if (m_st == 1) plan(opcode, funct);
          if (m_q.size() == 0) begin
            m_st = 0;
            m_ret++;
          end else begin
            m_st = m_q.pop_front();
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] snap_aop;
  logic       snap_pcw, snap_rdst, snap_m2r;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Run one instruction from FETCH; 'stall' not-ready cycles are inserted in
  // the first data-memory step. Ends back in FETCH or in FAULT.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int stall,
                           output int cyc, output int nmem);
    int left;
    left = stall;
    opcode = op; funct = fn;
    cyc = 0; nmem = 0;
    do begin
      if (state == 4'd6)  snap_aop  = alu_op;
      if (state == 4'd10) snap_pcw  = pc_write;
      if (state == 4'd7)  snap_rdst = reg_dst;
      if (state == 4'd4)  snap_m2r  = mem_to_reg;
      if (state == 4'd3 || state == 4'd5) begin
        nmem++;
        mem_ready = (left == 0);
        if (left > 0) left--;
      end else begin
        mem_ready = 1'b1;
      end
      tick();
      cyc++;
    end while (state != 4'd0 && state != 4'd15 && cyc < 64);
    mem_ready = 1'b1;
    if (cyc >= 64) chk("instr_bound", 32'(cyc), 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mem_ready = 1'b1;
  endtask

  int cyc, nmem, r0;

  initial begin
    // Reset with random inputs
    repeat (3) begin
      opcode = 6'($urandom); funct = 6'($urandom);
      alu_zero = 1'($urandom); mem_ready = 1'($urandom);
      tick();
      chk("clr_mem_req", 32'(mem_req), 32'd0);
      chk("clr_retired", 32'(retired), 32'd0);
    end
    opcode = 6'b000000; funct = 6'b100010; mem_ready = 1'b1;
    clear = 1'b0;
    #1;
    chk("first_state", 32'(state), 32'd0);
    chk("first_mem_req", 32'(mem_req), 32'd1);

    // R-type sub
    run_instr(6'b000000, 6'b100010, 0, cyc, nmem);
    chk("sub_cycles", 32'(cyc), 32'd4);
    chk("sub_alu_op", 32'(snap_aop), 32'b0110);
    chk("sub_reg_dst", 32'(snap_rdst), 32'd1);
    chk("sub_retired", 32'(retired), 32'd1);

    // lw with 3 stall cycles in MEM_READ
    run_instr(6'b100011, 6'b000000, 3, cyc, nmem);
    chk("lw_cycles", 32'(cyc), 32'd8);
    chk("lw_memread_cycles", 32'(nmem), 32'd4);
    chk("lw_mem_to_reg", 32'(snap_m2r), 32'd1);

    // beq not taken, then taken
    alu_zero = 1'b0;
    run_instr(6'b000100, 6'b000000, 0, cyc, nmem);
    chk("beq0_cycles", 32'(cyc), 32'd3);
    chk("beq0_pc_write", 32'(snap_pcw), 32'd0);
    alu_zero = 1'b1;
    run_instr(6'b000100, 6'b000000, 0, cyc, nmem);
    chk("beq1_cycles", 32'(cyc), 32'd3);
    chk("beq1_pc_write", 32'(snap_pcw), 32'd1);
    chk("beq_retired", 32'(retired), 32'd4);
    alu_zero = 1'b0;

    // Remaining legal instructions, checked by the per-cycle model
    run_instr(6'b101011, 6'b000000, 2, cyc, nmem);
    chk("sw_cycles", 32'(cyc), 32'd6);
    run_instr(6'b001000, 6'b000000, 0, cyc, nmem);
    run_instr(6'b001100, 6'b000000, 0, cyc, nmem);
    run_instr(6'b001101, 6'b000000, 0, cyc, nmem);
    chk("ori_cycles", 32'(cyc), 32'd4);
    run_instr(6'b000010, 6'b000000, 0, cyc, nmem);
    chk("j_cycles", 32'(cyc), 32'd3);
    run_instr(6'b000000, 6'b100000, 0, cyc, nmem);
    run_instr(6'b000000, 6'b100100, 0, cyc, nmem);
    run_instr(6'b000000, 6'b100101, 0, cyc, nmem);
    run_instr(6'b000000, 6'b101010, 0, cyc, nmem);
    chk("slt_alu_op", 32'(snap_aop), 32'b0111);
    chk("mix_retired", 32'(retired), 32'd13);

    // FETCH ready on the very last allowed cycle completes normally
    opcode = 6'b000010;
    mem_ready = 1'b0;
    repeat (15) tick();
    chk("fetch_late_hold", 32'(state), 32'd0);
    mem_ready = 1'b1;
    tick();
    chk("fetch_late_decode", 32'(state), 32'd1);
    repeat (2) tick();

    // FETCH timeout
    mem_ready = 1'b0;
    repeat (15) tick();
    chk("tmo_hold", 32'(state), 32'd0);
    tick();
    chk("tmo_state", 32'(state), 32'd15);
    chk("tmo_fault", 32'(fault), 32'd1);
    chk("tmo_mem_req", 32'(mem_req), 32'd0);
    mem_ready = 1'b1;
    repeat (4) tick();
    chk("fault_sticky", 32'(state), 32'd15);
    do_clear();

    // Illegal opcode
    run_instr(6'b111111, 6'b000000, 0, cyc, nmem);
    chk("illop_cycles", 32'(cyc), 32'd2);
    chk("illop_fault", 32'(fault), 32'd1);
    chk("illop_retired", 32'(retired), 32'd0);
    do_clear();

    // Illegal funct
    run_instr(6'b000000, 6'b000000, 0, cyc, nmem);
    chk("illfn_cycles", 32'(cyc), 32'd3);
    chk("illfn_state", 32'(state), 32'd15);
    do_clear();

    // MEM_READ timeout
    run_instr(6'b100011, 6'b000000, 40, cyc, nmem);
    chk("rd_tmo_cycles", 32'(cyc), 32'd19);
    chk("rd_tmo_state", 32'(state), 32'd15);
    do_clear();

    // clear asserted during R_WB
    run_instr(6'b000010, 6'b000000, 0, cyc, nmem);
    opcode = 6'b000000; funct = 6'b100000;
    repeat (3) tick();
    chk("mid_state", 32'(state), 32'd7);
    clear = 1'b1;
    #1;
    chk("mid_reg_write", 32'(reg_write), 32'd0);
    chk("mid_state_clr", 32'(state), 32'd0);
    chk("mid_retired", 32'(retired), 32'd0);
    tick();
    clear = 1'b0;

    // Retired counter wrap
    r0 = 0;
    for (int i = 0; i < 16; i++) begin
      run_instr(6'b000010, 6'b000000, 0, cyc, nmem);
      if (i == 14) r0 = int'(retired);
    end
    chk("wrap_15", 32'(r0), 32'd15);
    chk("wrap_0", 32'(retired), 32'd0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style FSM sequencer for the next-generation multi-cycle MIPS datapath. The datapath shares one memory for instruction and data, and has IR, A/B, MDR and ALUOut registers.
- Each instruction is broken into fetch/decode/execute/memory/writeback steps. The block issues per-cycle datapath controls and a request/ready handshake to a variable-latency memory.
- Adds a memory timeout, a sticky fault state for illegal opcodes, and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16, max cycles waiting for mem_ready in one memory state before FAULT; 0 disables the timeout.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26]; stable from DECODE until return to FETCH.
- funct  in  6  IR[5:0].
- alu_zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  request is a store.
- i_or_d  out  1  memory address source: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR (and latch instruction).
- pc_write  out  1  load PC.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B: 00 = B register, 01 = const 4, 10 = extended immediate, 11 = sign-extended immediate << 2.
- ext_sel  out  1  immediate extension: 0 = sign, 1 = zero.
- alu_op  out  4  ALU function: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- fault  out  1  sticky; FSM is in FAULT.
- retired  out  CNT_W  count of completed instructions.
- state  out  4  current state encoding, for debug.

Behaviour:
- States and encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, I_EXEC=8, I_WB=9, BRANCH=10, JUMP=11, FAULT=15.
- While clear is high:
  - state = FETCH, retired = 0, wait counter = 0.
  - All control outputs = 0, including mem_req; fault = 0.
- After clear deasserts, the first cycle is FETCH.
- Outputs are combinational from state, plus mem_ready/alu_zero where noted. Any control not listed for a state = 0; alu_op defaults to 0010.
- FETCH:
  - mem_req = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = add.
  - When mem_ready = 1: ir_write = 1, pc_write = 1, pc_source = 00, next state DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a = 0, alu_src_b = 11, add. Next state by opcode:
  - 000000 → R_EXEC
  - 100011 / 101011 → MEM_ADDR
  - 001000 / 001100 / 001101 → I_EXEC
  - 000100 → BRANCH
  - 000010 → JUMP
  - anything else → FAULT
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, ext_sel = 0, add. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_req = 1, i_or_d = 1. Next state MEM_WB when mem_ready = 1.
- MEM_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 1. Next state FETCH.
- MEM_WRITE: mem_req = 1, mem_write = 1, i_or_d = 1. Next state FETCH when mem_ready = 1.
- R_EXEC:
  - alu_src_a = 1, alu_src_b = 00.
  - alu_op from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other funct → FAULT. Otherwise next state R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Next state FETCH.
- I_EXEC:
  - alu_src_a = 1, alu_src_b = 10.
  - addi: add, ext_sel = 0. andi: and, ext_sel = 1. ori: or, ext_sel = 1.
  - Next state I_WB.
- I_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Next state FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, sub, pc_source = 01, pc_write = alu_zero. Next state FETCH.
- JUMP: pc_write = 1, pc_source = 10. Next state FETCH.
- FAULT: fault = 1, all other controls 0. FAULT is terminal; only clear exits it.
- Wait counter:
  - Cleared on entry to FETCH, MEM_READ and MEM_WRITE; increments each cycle mem_ready = 0 in those states.
  - With MEM_TIMEOUT ≠ 0: if the counter reaches MEM_TIMEOUT−1 with mem_ready still 0, next state is FAULT.
  - mem_ready = 1 on that same cycle wins; the access completes normally.
- retired:
  - Increments by 1 on the cycle leaving MEM_WB, R_WB, I_WB, BRANCH or JUMP, and on MEM_WRITE completion.
  - Wraps modulo 2^CNT_W; never increments on entry to FAULT.
- Latency with mem_ready tied to 1: R-type 4 cycles, addi/andi/ori 4, lw 5, sw 4, beq 3, j 3.
- clear mid-instruction: state returns to FETCH asynchronously and all outputs drop in the same cycle; no partial writeback occurs after clear.

Test Plan:
- Reset: clear = 1 for 3 cycles with random inputs → all outputs 0, retired = 0. Release with mem_ready = 1 → state = 0, mem_req = 1 in the first cycle.
- mem_ready = 1; opcode 000000, funct 100010 → states 0,1,6,7. alu_op = 0110 in R_EXEC; reg_write = 1, reg_dst = 1 in R_WB; retired = 1.
- lw (100011) with mem_ready low for 3 cycles in MEM_READ → MEM_READ held 4 cycles with mem_req = 1, i_or_d = 1. MEM_WB then has mem_to_reg = 1; total 8 cycles.
- beq with alu_zero = 0, then with alu_zero = 1 → pc_write 0, then 1, with pc_source = 01. Each takes 3 cycles; retired += 2.
- MEM_TIMEOUT = 16, mem_ready held 0 in FETCH → FAULT after 16 cycles, fault = 1, mem_req = 0. State stays at 15 until clear.
- Opcode 111111 → FAULT after DECODE. CNT_W = 4 with 16 jumps → retired wraps to 0.
